ieee_divider: RTL
=================

IEEE_DIVIDER -- requirements
Module: ieee_divider

Interface
REQ-001 Parameter: none; the format is fixed at IEEE-754 single precision (32-bit).
REQ-002 Port clk: input, 1 bit, the single clock; all state updates on posedge clk.
REQ-003 Port rst: input, 1 bit, synchronous active-high reset, sampled on posedge clk.
REQ-004 Port start: input, 1 bit, request to begin a division; sampled only while idle.
REQ-005 Port number1: input, 32 bits, dividend, IEEE-754 single; captured when start is accepted.
REQ-006 Port number2: input, 32 bits, divisor, IEEE-754 single; captured when start is accepted.
REQ-007 Port busy: output, 1 bit, high from the cycle after start is accepted until done is asserted.
REQ-008 Port done: output, 1 bit, single-cycle pulse when result is valid.
REQ-009 Port result: output, 32 bits, quotient number1/number2; holds its value until the next done.

Function
REQ-010 The FSM SHALL have states IDLE, DIVIDE, NORM and DONE, with transitions IDLE->DIVIDE (start=1), DIVIDE->NORM (after 25 iterations), NORM->DONE, DONE->IDLE.
REQ-011 In IDLE, start=1 SHALL capture both operands and the sign result = number1[31] ^ number2[31].
REQ-012 start SHALL be ignored while busy=1 or while in DONE; operands SHALL NOT be re-captured.
REQ-013 DIVIDE SHALL run restoring division of Ma={1,frac1} by Mb={1,frac2}: remainder R starts at Ma; each cycle q_i=(R>=Mb), R-=Mb if q_i, R<<=1; 25 quotient bits q[24:0], MSB first.
REQ-014 The remainder register SHALL be 25 bits wide to hold R<<1 without loss.
REQ-015 The biased exponent SHALL be computed as a 10-bit signed value E=Ea-Eb+127.
REQ-016 In NORM: if q[24]=1, then mantissa=q[23:1] and exponent=E; otherwise mantissa=q[22:0] and exponent=E-1.
REQ-017 Rounding SHALL be truncation (round toward zero); no guard or sticky bits are kept.
REQ-018 A final exponent >=255 SHALL produce a signed infinity {s,8'hFF,23'h0}.
REQ-019 A final exponent <=0 SHALL produce a signed zero; no subnormal output is generated.
REQ-020 Special cases SHALL be classified at capture, with operands of exponent 0 treated as zero (subnormals flushed).
REQ-021 NaN operand, 0/0 and inf/inf SHALL return 32'h7FC00000, with the sign ignored.
REQ-022 x/0 with x non-zero, and inf/x, SHALL return signed infinity.
REQ-023 0/x and x/inf SHALL return signed zero.
REQ-024 Special cases SHALL use the same FSM path and latency as normal operands; the result is overridden in NORM.
REQ-025 Latency SHALL be fixed: done=1 exactly 27 cycles after the cycle in which start is sampled high.
REQ-026 result SHALL update on the same edge that asserts done.
REQ-027 A new start SHALL be accepted in the cycle after done, with no dead cycle beyond DONE->IDLE.

Reset
REQ-028 rst=1 SHALL force state=IDLE, busy=0, done=0, result=32'h0 and clear the quotient/remainder/iteration counter on the next posedge.
REQ-029 rst asserted mid-operation SHALL abort the division with no done pulse; rst SHALL take priority over start in the same cycle.

Structure
REQ-030 Package ieee_fp_pkg SHALL hold the FSM state enum, BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000 and the field-width constants.
REQ-031 Operand classification (zero/inf/NaN) SHALL be one sub-module, ieee_fp_classify, instantiated once per operand.
REQ-032 The iteration counter SHALL be 5 bits wide and count 0..24.

Verification
REQ-033 40C00000 / 40000000 (6.0/2.0) -> result 40400000, done exactly 27 cycles after start.
REQ-034 3F800000 / 40400000 (1/3) -> result 3EAAAAAA (truncated).
REQ-035 BF800000 / 00000000 -> result FF800000; 00000000 / 00000000 -> result 7FC00000.
REQ-036 7F000000 / 3E800000 -> result 7F800000 (overflow); 00800000 / 4B000000 -> result 00000000 (underflow).
REQ-037 Start a division, assert rst at cycle 10 -> busy=0, done=0, result=0 on the next cycle, and no done pulse ever for that operation.
REQ-038 Pulse start again at cycle 5 with different operands -> ignored; the first result is returned unchanged at cycle 27.

Source files
------------

// File: rtl/ieee_fp_pkg.sv
// Shared types and constants for the single-precision divider.
package ieee_fp_pkg;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int MANT_W  = 24;
  localparam int QUO_W   = 25;
  localparam int REM_W   = 25;
  localparam int CNT_W   = 5;
  localparam int ITERS   = 25;
  localparam int EXPC_W  = 10;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic signed [EXPC_W-1:0] BIAS_S    = EXPC_W'(BIAS);
  localparam logic signed [EXPC_W-1:0] EXP_MAX_S = EXPC_W'(EXP_MAX);

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM, S_DONE} state_e;
  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_e;

  // Invalid cases first so inf/inf and 0/0 never fall through to inf or zero.
  function automatic special_e classify_pair(input logic az, ai, an, bz, bi, bn);
    if (an || bn || (az && bz) || (ai && bi)) return SP_NAN;
    if (ai || bz) return SP_INF;
    if (az || bi) return SP_ZERO;
    return SP_NONE;
  endfunction
endpackage

// File: rtl/ieee_fp_classify.sv
// Zero/inf/NaN flags for one operand; exponent 0 counts as zero (subnormals flushed).
module ieee_fp_classify
  import ieee_fp_pkg::*;
(
  input  logic [30:0] op,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan
);
  logic [EXP_W-1:0]  e;
  logic [FRAC_W-1:0] f;

  assign e       = op[30:FRAC_W];
  assign f       = op[FRAC_W-1:0];
  assign is_zero = (e == '0);
  assign is_inf  = (e == '1) && (f == '0);
  assign is_nan  = (e == '1) && (f != '0);
endmodule

// File: rtl/ieee_divider.sv
// Multi-cycle IEEE-754 single divider: 25-step restoring mantissa divide,
// one normalise cycle, one done cycle; truncating, no subnormal output.
module ieee_divider
  import ieee_fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] number1,
  input  logic [31:0] number2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  state_e state, state_nxt;

  logic                     sign_q;
  special_e                 spec_q;
  logic [MANT_W-1:0]        mb_q;
  logic [REM_W-1:0]         rem_q;
  logic [QUO_W-1:0]         quo_q;
  logic [CNT_W-1:0]         cnt_q;
  logic signed [EXPC_W-1:0] exp_q;
  logic [31:0]              res_pend;

  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic last_iter, q_bit;
  logic [REM_W-1:0]         rem_sub;
  logic signed [EXPC_W-1:0] e_fin;
  logic [FRAC_W-1:0]        m_fin;
  logic [31:0]              norm_res;

  ieee_fp_classify u_cls_a (.op(number1[30:0]), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan));
  ieee_fp_classify u_cls_b (.op(number2[30:0]), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan));

  assign busy      = (state != S_IDLE);
  assign last_iter = (cnt_q == CNT_W'(ITERS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_DIVIDE;
      S_DIVIDE: if (last_iter) state_nxt = S_NORM;
      S_NORM:   state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // One restoring step: R < 2*Mb always holds, so R<<1 fits in 25 bits.
  assign q_bit   = (rem_q >= {1'b0, mb_q});
  assign rem_sub = q_bit ? rem_q - {1'b0, mb_q} : rem_q;

  always_comb begin
    e_fin = exp_q;
    m_fin = quo_q[QUO_W-2:1];
    if (!quo_q[QUO_W-1]) begin
      e_fin = exp_q - 10'sd1;
      m_fin = quo_q[FRAC_W-1:0];
    end
    norm_res = {sign_q, e_fin[EXP_W-1:0], m_fin};
    if (e_fin >= EXP_MAX_S)  norm_res = {sign_q, 8'hFF, 23'h0};
    else if (e_fin <= 10'sd0) norm_res = {sign_q, 31'h0};
    case (spec_q)
      SP_NAN:  norm_res = QNAN;
      SP_INF:  norm_res = {sign_q, 8'hFF, 23'h0};
      SP_ZERO: norm_res = {sign_q, 31'h0};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q   <= 1'b0;
      spec_q   <= SP_NONE;
      mb_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      exp_q    <= '0;
      res_pend <= '0;
      result   <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          sign_q <= number1[31] ^ number2[31];
          spec_q <= classify_pair(a_zero, a_inf, a_nan, b_zero, b_inf, b_nan);
          mb_q   <= {1'b1, number2[FRAC_W-1:0]};
          rem_q  <= {2'b01, number1[FRAC_W-1:0]};
          quo_q  <= '0;
          cnt_q  <= '0;
          exp_q  <= $signed({2'b00, number1[30:FRAC_W]})
                  - $signed({2'b00, number2[30:FRAC_W]}) + BIAS_S;
        end
        S_DIVIDE: begin
          quo_q <= {quo_q[QUO_W-2:0], q_bit};
          rem_q <= rem_sub << 1;
          if (!last_iter) cnt_q <= cnt_q + 1'b1;
        end
        S_NORM: res_pend <= norm_res;
        S_DONE: begin
          result <= res_pend;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
